// File: rtl/kaipokrandt_mem_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : kaipokrandt_mem_ctrl_pkg
// Brief    : Shared word width, wait-counter width, FSM state encoding and
//            address range helper for the memory-side responder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package kaipokrandt_mem_ctrl_pkg;

   localparam int WORD_W = 16;
   // Wait counter wide enough for 0..15 configured wait states
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // True when a word address falls inside the implemented array
   function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
      return (addr < depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/kaipokrandt_mem_ctrl_ram_array.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : kaipokrandt_mem_ctrl_ram_array
// Brief    : Single-port synchronous word RAM with registered read port.
//            Out-of-range writes are dropped, out-of-range reads return zero.
//            Array contents are never reset; only the read register is.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module kaipokrandt_mem_ctrl_ram_array
   import kaipokrandt_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] dout
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_dout;
   logic              w_in_range;
   logic [IDX_W-1:0]  w_idx;

   assign w_in_range = addr_in_range(32'(addr), DEPTH);
   assign w_idx      = addr[IDX_W-1:0];
   assign dout       = r_dout;

   // Array write port; contents survive reset
   always_ff @(posedge clk) begin
      if (we && w_in_range) begin
         r_mem[w_idx] <= din;
      end
   end

   // Registered read port; holds last read value between reads
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dout <= '0;
      end else if (re) begin
         r_dout <= w_in_range ? r_mem[w_idx] : '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/kaipokrandt_mem_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : kaipokrandt_mem_ctrl
// Brief    : Memory-side responder for the MDR/MAR datapath. Accepts one
//            read or write at a time, waits WAIT_STATES cycles, accesses the
//            word RAM, then pulses done (and load_mem for reads).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module kaipokrandt_mem_ctrl
   import kaipokrandt_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] mar_addr,
   input  logic [WORD_W-1:0] mem_din,
   output logic [WORD_W-1:0] mem_dout,
   output logic              load_mem,
   output logic              done,
   output logic              busy,
   output logic              err
);

   localparam logic [CNT_W-1:0] C_WAIT_INIT = CNT_W'(WAIT_STATES);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [WORD_W-1:0] r_data;
   logic              r_is_wr;
   logic              r_done;
   logic              r_load;
   logic              r_busy;
   logic              r_err;
   logic              w_capture;
   logic              w_access;
   logic              w_addr_ok;
   logic              w_done_nxt;
   logic              w_load_nxt;
   logic              w_err_nxt;

   // Range check on the captured address, not the live MAR value
   assign w_addr_ok = addr_in_range(32'(r_addr), DEPTH);

   // Next-state, wait counter and registered-output next values
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      w_access    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (rd_req ^ wr_req) begin
               w_capture   = 1'b1;
               w_cnt_nxt   = C_WAIT_INIT;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_access    = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_done_nxt = w_access;
      w_load_nxt = w_access && !r_is_wr;
      // Conflicting request in IDLE, or an out-of-range access completing
      w_err_nxt  = ((r_state == ST_IDLE) && rd_req && wr_req) || (w_access && !w_addr_ok);
   end

   // State and wait counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Request capture; later MAR/MDR changes must not affect the access
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr  <= '0;
         r_data  <= '0;
         r_is_wr <= 1'b0;
      end else if (w_capture) begin
         r_addr  <= mar_addr;
         r_data  <= mem_din;
         r_is_wr <= wr_req;
      end
   end

   // Status outputs are registered so nothing combinational reaches a port
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_done <= 1'b0;
         r_load <= 1'b0;
         r_busy <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_done <= w_done_nxt;
         r_load <= w_load_nxt;
         r_busy <= (w_state_nxt != ST_IDLE);
         r_err  <= w_err_nxt;
      end
   end

   kaipokrandt_mem_ctrl_ram_array #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (w_access && r_is_wr),
      .re    (w_access && !r_is_wr),
      .addr  (r_addr),
      .din   (r_data),
      .dout  (mem_dout)
   );

   assign done     = r_done;
   assign load_mem = r_load;
   assign busy     = r_busy;
   assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_kaipokrandt_mem_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_kaipokrandt_mem_ctrl
// Brief    : Self-checking bench for three responder configurations sharing
//            one request bus: (DEPTH 256, WS 1), (DEPTH 200, WS 3),
//            (DEPTH 256, WS 0). Expectations come from a word-array model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_kaipokrandt_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rd_req = 1'b0;
   logic        wr_req = 1'b0;
   logic [7:0]  mar_addr = '0;
   logic [15:0] mem_din = '0;

   logic [2:0]  done_v;
   logic [2:0]  load_v;
   logic [2:0]  busy_v;
   logic [2:0]  err_v;
   logic [15:0] dout_v [3];

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] model_mem  [3][256];
   bit          model_ok   [3][256];
   logic [15:0] model_dout [3];
   int          written_q [$];

   always #5 clk = ~clk;

   kaipokrandt_mem_ctrl #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(1)) dut_a (
      .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req),
      .mar_addr(mar_addr), .mem_din(mem_din), .mem_dout(dout_v[0]),
      .load_mem(load_v[0]), .done(done_v[0]), .busy(busy_v[0]), .err(err_v[0]));

   kaipokrandt_mem_ctrl #(.ADDR_W(8), .DEPTH(200), .WAIT_STATES(3)) dut_b (
      .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req),
      .mar_addr(mar_addr), .mem_din(mem_din), .mem_dout(dout_v[1]),
      .load_mem(load_v[1]), .done(done_v[1]), .busy(busy_v[1]), .err(err_v[1]));

   kaipokrandt_mem_ctrl #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) dut_c (
      .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req),
      .mar_addr(mar_addr), .mem_din(mem_din), .mem_dout(dout_v[2]),
      .load_mem(load_v[2]), .done(done_v[2]), .busy(busy_v[2]), .err(err_v[2]));

   function automatic int ws_of(input int i);
      case (i)
         0:       return 1;
         1:       return 3;
         default: return 0;
      endcase
   endfunction

   function automatic int depth_of(input int i);
      return (i == 1) ? 200 : 256;
   endfunction

   // One accepted access on all three DUTs, checked against the model
   task automatic do_op(input bit rd, input bit wr, input logic [7:0] a,
                        input logic [15:0] d, input bit poke);
      int          first [3];
      int          ndone [3];
      bit          oor   [3];
      bit          chk_d [3];
      logic [15:0] exp_d [3];
      for (int i = 0; i < 3; i++) begin
         first[i] = -1;
         ndone[i] = 0;
         oor[i]   = (int'(a) >= depth_of(i));
         chk_d[i] = 1'b1;
         if (rd) begin
            if (oor[i]) exp_d[i] = 16'h0000;
            else if (model_ok[i][a]) exp_d[i] = model_mem[i][a];
            else begin exp_d[i] = 16'h0000; chk_d[i] = 1'b0; end
         end else begin
            exp_d[i] = model_dout[i];
         end
      end
      @(negedge clk);
      rd_req = rd; wr_req = wr; mar_addr = a; mem_din = d;
      @(posedge clk);
      @(negedge clk);
      rd_req = 1'b0; wr_req = 1'b0;
      mar_addr = 8'($urandom); mem_din = 16'($urandom);
      if (poke) begin
         rd_req = 1'b1;
         wr_req = 1'($urandom);
      end
      n_tests++;
      if (busy_v !== 3'b111) begin
         n_fail++;
         $display("FAIL busy_after_accept addr=%h: got %b, expected 111", a, busy_v);
      end
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) begin rd_req = 1'b0; wr_req = 1'b0; end
         for (int i = 0; i < 3; i++) begin
            if (done_v[i] === 1'b1) begin
               ndone[i]++;
               if (first[i] < 0) begin
                  first[i] = k;
                  n_tests++;
                  if (load_v[i] !== rd) begin
                     n_fail++;
                     $display("FAIL load_mem dut%0d addr=%h: got %b, expected %b", i, a, load_v[i], rd);
                  end
                  n_tests++;
                  if (err_v[i] !== oor[i]) begin
                     n_fail++;
                     $display("FAIL err_with_done dut%0d addr=%h: got %b, expected %b", i, a, err_v[i], oor[i]);
                  end
                  if (chk_d[i]) begin
                     n_tests++;
                     if (dout_v[i] !== exp_d[i]) begin
                        n_fail++;
                        $display("FAIL mem_dout dut%0d addr=%h: got %h, expected %h", i, a, dout_v[i], exp_d[i]);
                     end
                  end
               end
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (first[i] != ws_of(i) + 1) begin
            n_fail++;
            $display("FAIL latency dut%0d addr=%h: got %0d, expected %0d", i, a, first[i], ws_of(i) + 1);
         end
         n_tests++;
         if (ndone[i] != 1 || busy_v[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done dut%0d addr=%h: got done_count=%0d busy=%b, expected 1 and 0", i, a, ndone[i], busy_v[i]);
         end
         if (rd) model_dout[i] = exp_d[i];
         if (wr && !oor[i]) begin
            model_mem[i][a] = d;
            model_ok[i][a]  = 1'b1;
         end
      end
      if (wr) written_q.push_back(int'(a));
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if ({busy_v[i], done_v[i], load_v[i], err_v[i], dout_v[i]} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: got busy=%b done=%b load=%b err=%b dout=%h, expected all 0",
                     i, busy_v[i], done_v[i], load_v[i], err_v[i], dout_v[i]);
         end
         model_dout[i] = 16'h0000;
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      do_op(1'b0, 1'b1, 8'h12, 16'hBEEF, 1'b0);
      do_op(1'b1, 1'b0, 8'h12, 16'($urandom), 1'b0);
   endtask

   task automatic test_both_req();
      do_op(1'b0, 1'b1, 8'h05, 16'h1234, 1'b0);
      @(negedge clk);
      rd_req = 1'b1; wr_req = 1'b1; mar_addr = 8'h05; mem_din = 16'hDEAD;
      @(posedge clk);
      @(negedge clk);
      rd_req = 1'b0; wr_req = 1'b0;
      n_tests++;
      if (err_v !== 3'b111 || done_v !== 3'b000 || busy_v !== 3'b000) begin
         n_fail++;
         $display("FAIL both_req_pulse: got err=%b done=%b busy=%b, expected 111 000 000", err_v, done_v, busy_v);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_tests++;
         if (err_v !== 3'b000 || done_v !== 3'b000 || busy_v !== 3'b000) begin
            n_fail++;
            $display("FAIL both_req_after: got err=%b done=%b busy=%b, expected 000 000 000", err_v, done_v, busy_v);
         end
      end
      do_op(1'b1, 1'b0, 8'h05, 16'h0000, 1'b0);
   endtask

   task automatic test_out_of_range();
      do_op(1'b0, 1'b1, 8'hF0, 16'hCAFE, 1'b0);
      do_op(1'b1, 1'b0, 8'hF0, 16'h0000, 1'b0);
      do_op(1'b1, 1'b0, 8'h12, 16'h0000, 1'b0);
   endtask

   task automatic test_busy_ignore();
      do_op(1'b1, 1'b0, 8'h12, 16'h0000, 1'b1);
      do_op(1'b0, 1'b1, 8'h40, 16'h5A5A, 1'b1);
      do_op(1'b1, 1'b0, 8'h40, 16'h0000, 1'b1);
   endtask

   task automatic test_reset_mid_op();
      do_op(1'b0, 1'b1, 8'h33, 16'h1111, 1'b0);
      @(negedge clk);
      wr_req = 1'b1; mar_addr = 8'h33; mem_din = 16'h2222;
      @(posedge clk);
      @(negedge clk);
      wr_req = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if ({busy_v[i], done_v[i], load_v[i], err_v[i], dout_v[i]} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid_op dut%0d: got busy=%b done=%b load=%b err=%b dout=%h, expected all 0",
                     i, busy_v[i], done_v[i], load_v[i], err_v[i], dout_v[i]);
         end
         model_dout[i] = 16'h0000;
         // Only the zero-wait configuration reached its array edge
         if (ws_of(i) == 0) model_mem[i][8'h33] = 16'h2222;
      end
      @(negedge clk);
      reset = 1'b1;
      do_op(1'b1, 1'b0, 8'h33, 16'h0000, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         if (written_q.size() == 0 || $urandom_range(1, 0) == 1) begin
            do_op(1'b0, 1'b1, 8'($urandom), 16'($urandom), 1'($urandom));
         end else begin
            do_op(1'b1, 1'b0, 8'(written_q[$urandom_range(written_q.size() - 1, 0)]),
                  16'($urandom), 1'($urandom));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write_read();
      test_both_req();
      test_out_of_range();
      test_busy_ignore();
      test_reset_mid_op();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
